// File: rtl/mole_controller.sv
// Whack-a-mole core: raises one pseudo-random mole per spawn pulse and judges
// debounced button presses as hit, wrong press or timeout with saturating scores.
module mole_controller #(
  parameter int          NUM_MOLES  = 4,
  parameter int          IDX_W      = 2,
  parameter int          SCORE_W    = 8,
  parameter int          TICKS_EASY = 200000000,
  parameter int          TICKS_MED  = 120000000,
  parameter int          TICKS_HARD = 70000000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           difficulty,
  input  logic [NUM_MOLES-1:0] buttons,
  output logic [NUM_MOLES-1:0] mole_leds,
  output logic                 mole_active,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses
);

  localparam int TIMER_W = 32;

  typedef enum logic {IDLE, UP} state_t;

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [NUM_MOLES-1:0] btn_q, btn_d;
  logic [IDX_W-1:0]     last_idx_q, last_idx_d;
  logic                 last_valid_q, last_valid_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [NUM_MOLES-1:0] mole_leds_q, mole_leds_d;
  logic                 hit_pulse_q, hit_pulse_d;
  logic                 miss_pulse_q, miss_pulse_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   misses_q, misses_d;

  logic [NUM_MOLES-1:0] press;
  logic [IDX_W-1:0]     cand;
  logic [IDX_W-1:0]     spawn_idx;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [TIMER_W-1:0] ticks_for(input logic [1:0] d);
    case (d)
      2'b00:   return TIMER_W'(TICKS_EASY - 1);
      2'b01:   return TIMER_W'(TICKS_MED - 1);
      default: return TIMER_W'(TICKS_HARD - 1);
    endcase
  endfunction

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 in right-shift form
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  assign press = buttons & ~btn_q;
  assign cand  = lfsr_q[IDX_W-1:0];

  // Never spawn twice in a row at the same spot; power-of-two width wraps the +1
  assign spawn_idx = (last_valid_q && (cand == last_idx_q)) ? cand + 1'b1 : cand;

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_step(lfsr_q);
    btn_d        = buttons;
    last_idx_d   = last_idx_q;
    last_valid_d = last_valid_q;
    timer_d      = timer_q;
    mole_leds_d  = mole_leds_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    score_d      = score_q;
    misses_d     = misses_q;

    case (state_q)
      IDLE: begin
        if (enable && (difficulty != 2'b11)) begin
          mole_leds_d  = NUM_MOLES'(1) << spawn_idx;
          last_idx_d   = spawn_idx;
          last_valid_d = 1'b1;
          timer_d      = ticks_for(difficulty);
          state_d      = UP;
        end
      end
      UP: begin
        // Any stray press loses, even when the right button is pressed too
        if (|(press & ~mole_leds_q)) begin
          misses_d     = sat_inc(misses_q);
          miss_pulse_d = 1'b1;
          mole_leds_d  = '0;
          state_d      = IDLE;
        end else if (|(press & mole_leds_q)) begin
          score_d      = sat_inc(score_q);
          hit_pulse_d  = 1'b1;
          mole_leds_d  = '0;
          state_d      = IDLE;
        end else if (timer_q == '0) begin
          misses_d     = sat_inc(misses_q);
          miss_pulse_d = 1'b1;
          mole_leds_d  = '0;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      btn_q        <= '0;
      last_idx_q   <= '0;
      last_valid_q <= 1'b0;
      timer_q      <= '0;
      mole_leds_q  <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      score_q      <= '0;
      misses_q     <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      btn_q        <= btn_d;
      last_idx_q   <= last_idx_d;
      last_valid_q <= last_valid_d;
      timer_q      <= timer_d;
      mole_leds_q  <= mole_leds_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      score_q      <= score_d;
      misses_q     <= misses_d;
    end
  end

  assign mole_leds   = mole_leds_q;
  assign mole_active = (state_q == UP);
  assign hit_pulse   = hit_pulse_q;
  assign miss_pulse  = miss_pulse_q;
  assign score       = score_q;
  assign misses      = misses_q;

endmodule

// File: tb/tb_mole_controller.sv
// Directed bench for mole_controller with short mole lifetimes and a reference LFSR.
module tb_mole_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] difficulty = 2'b00;
  logic [3:0] buttons = 4'b0000;
  logic [3:0] mole_leds;
  logic       mole_active;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [3:0] score;
  logic [3:0] misses;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_lfsr = 16'hACE1;
  int li = 0;
  bit lv = 1'b0;

  mole_controller #(
    .NUM_MOLES(4), .IDX_W(2), .SCORE_W(4),
    .TICKS_EASY(10), .TICKS_MED(6), .TICKS_HARD(3), .LFSR_SEED(16'hACE1)
  ) dut (
    .CLK100MHZ(clk), .reset(reset), .enable(enable), .difficulty(difficulty),
    .buttons(buttons), .mole_leds(mole_leds), .mole_active(mole_active),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score), .misses(misses)
  );

  always #5 clk = ~clk;

  // Reference LFSR, right-shift Fibonacci with taps 16,14,13,11
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic spawn(input logic [1:0] d, output int idx);
    int cand;
    cand = int'(m_lfsr[1:0]);
    idx = (lv && cand == li) ? (cand + 1) % 4 : cand;
    enable = 1'b1;
    difficulty = d;
    tick();
    enable = 1'b0;
    check("spawn_leds", 32'(mole_leds), 32'(1) << idx);
    check("spawn_act", 32'(mole_active), 32'd1);
    li = idx;
    lv = 1'b1;
  endtask

  initial begin
    int idx;
    int prev;
    int exp_score;
    bit found;

    tick(); tick();
    check("rst_leds", 32'(mole_leds), 32'd0);
    check("rst_act", 32'(mole_active), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_misses", 32'(misses), 32'd0);
    check("rst_pulses", 32'({hit_pulse, miss_pulse}), 32'd0);
    reset = 1'b0;
    tick();

    // Timeout at easy: visible exactly 10 cycles
    spawn(2'b00, idx);
    for (int i = 0; i < 9; i++) tick();
    check("to_still_up", 32'(mole_active), 32'd1);
    tick();
    check("to_miss", 32'(miss_pulse), 32'd1);
    check("to_misses", 32'(misses), 32'd1);
    check("to_leds", 32'(mole_leds), 32'd0);
    tick();
    check("to_pulse_end", 32'(miss_pulse), 32'd0);

    // Correct press two cycles after spawn
    spawn(2'b00, idx);
    tick();
    buttons = 4'(1 << idx);
    tick();
    check("hit_pulse", 32'(hit_pulse), 32'd1);
    check("hit_score", 32'(score), 32'd1);
    check("hit_idle", 32'(mole_active), 32'd0);
    buttons = 4'b0;
    tick();
    check("hit_pulse_end", 32'(hit_pulse), 32'd0);
    buttons = 4'(1 << idx);
    tick();
    check("idle_press", 32'({hit_pulse, miss_pulse, score}), 32'h01);
    buttons = 4'b0;
    tick();

    // Correct plus wrong press together
    spawn(2'b00, idx);
    buttons = 4'((1 << idx) | (1 << ((idx + 1) % 4)));
    tick();
    check("dual_miss", 32'(miss_pulse), 32'd1);
    check("dual_hit", 32'(hit_pulse), 32'd0);
    check("dual_misses", 32'(misses), 32'd2);
    check("dual_score", 32'(score), 32'd1);
    buttons = 4'b0;
    tick();

    // Spawning disabled
    difficulty = 2'b11;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dis_leds", 32'(mole_leds), 32'd0);
    end
    enable = 1'b0;
    tick();

    // Hard: mole up 3 cycles
    spawn(2'b10, idx);
    tick(); tick();
    check("hard_up", 32'(mole_active), 32'd1);
    tick();
    check("hard_miss", 32'(miss_pulse), 32'd1);
    check("hard_misses", 32'(misses), 32'd3);
    tick();

    // Wait until the candidate repeats the last index
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      if (int'(m_lfsr[1:0]) == li) found = 1'b1;
      else tick();
    end
    check("rep_found", 32'(found), 32'd1);
    prev = li;
    spawn(2'b00, idx);
    check("rep_leds", 32'(mole_leds), 32'(1) << ((prev + 1) % 4));
    buttons = 4'(1 << idx);
    tick();
    check("rep_hit", 32'(score), 32'd2);
    buttons = 4'b0;
    tick();

    // Held buttons across spawn do not count
    buttons = 4'hF;
    tick();
    spawn(2'b00, idx);
    tick();
    check("held_nopulse", 32'({hit_pulse, miss_pulse}), 32'd0);
    check("held_up", 32'(mole_active), 32'd1);
    buttons = 4'b0;
    tick();
    check("rel_nopulse", 32'({hit_pulse, miss_pulse, mole_active}), 32'd1);
    buttons = 4'(1 << idx);
    tick();
    check("repress_hit", 32'(hit_pulse), 32'd1);
    check("repress_score", 32'(score), 32'd3);
    buttons = 4'b0;
    tick();

    // Hit on the timer==0 cycle beats timeout
    spawn(2'b10, idx);
    tick(); tick();
    check("edge_up", 32'(mole_active), 32'd1);
    buttons = 4'(1 << idx);
    tick();
    check("edge_hit", 32'(hit_pulse), 32'd1);
    check("edge_nomiss", 32'(miss_pulse), 32'd0);
    check("edge_score", 32'(score), 32'd4);
    buttons = 4'b0;
    tick();

    // enable during UP is dropped
    spawn(2'b01, idx);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    check("en_up_leds", 32'(mole_leds), 32'(1) << idx);
    buttons = 4'(1 << idx);
    tick();
    check("en_up_score", 32'(score), 32'd5);
    buttons = 4'b0;
    tick();
    check("en_up_idle", 32'({mole_active, mole_leds}), 32'd0);

    // 16 consecutive hits saturate at 15
    exp_score = 5;
    for (int h = 0; h < 16; h++) begin
      spawn(2'b00, idx);
      buttons = 4'(1 << idx);
      tick();
      exp_score = (exp_score < 15) ? exp_score + 1 : 15;
      check("sat_score", 32'(score), 32'(exp_score));
      buttons = 4'b0;
      tick();
    end
    check("sat_final", 32'(score), 32'd15);

    // Reset mid-UP wins over a simultaneous hit
    spawn(2'b00, idx);
    tick();
    reset = 1'b1;
    buttons = 4'(1 << idx);
    tick();
    check("mid_rst_outs", 32'({mole_leds, mole_active, hit_pulse, miss_pulse}), 32'd0);
    check("mid_rst_cnt", 32'({score, misses}), 32'd0);
    reset = 1'b0;
    buttons = 4'b0;
    lv = 1'b0;
    li = 0;
    tick();
    check("post_rst_idle", 32'({mole_active, hit_pulse, miss_pulse}), 32'd0);
    spawn(2'b00, idx);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_controller.md
Name: mole_controller

Overview:
- Consumes the single-cycle spawn pulse from the difficulty-paced enable generator and raises one mole (LED) at a pseudo-random position.
- Judges the player's debounced button presses as a hit, wrong press or timeout, and keeps hit and miss scores.
- Sits between the enable generator and the display/score blocks of the whack-a-mole game.

Parameters:
- NUM_MOLES, 4, number of mole positions/buttons; power of two, 2..16.
- IDX_W, 2, log2(NUM_MOLES).
- SCORE_W, 8, width of score and miss counters.
- TICKS_EASY, 200000000, cycles a mole stays up at difficulty 2'b00.
- TICKS_MED, 120000000, cycles a mole stays up at difficulty 2'b01.
- TICKS_HARD, 70000000, cycles a mole stays up at difficulty 2'b10.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  one-cycle spawn request from the enable generator.
- difficulty  input  2  00 easy, 01 medium, 10 hard, 11 spawning disabled.
- buttons  input  NUM_MOLES  debounced, level-high player buttons.
- mole_leds  output  NUM_MOLES  one-hot while a mole is up, else 0.
- mole_active  output  1  high while in UP.
- hit_pulse  output  1  one-cycle pulse on a hit.
- miss_pulse  output  1  one-cycle pulse on a wrong press or timeout.
- score  output  SCORE_W  hit count, saturating.
- misses  output  SCORE_W  miss count, saturating.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - All state is updated on posedge CLK100MHZ.
  - While reset=1 at an edge: state=IDLE, mole_leds=0, mole_active=0, hit_pulse=0, miss_pulse=0, score=0, misses=0, lfsr=LFSR_SEED, btn_q=0, last_valid=0, timer=0.
  - Reset in the middle of a mole clears everything on that edge; no hit/miss pulse is produced.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Shifts every cycle when not in reset.
  - Candidate index = lfsr[IDX_W-1:0], using the value before the shift.
- Button edges:
  - btn_q is a registered copy of buttons.
  - press = buttons & ~btn_q (rising edges only).
  - A button already held when a mole rises does not count until it is released and pressed again.
- FSM states: IDLE, UP.
- IDLE:
  - press is ignored.
  - At an edge with enable=1 and difficulty != 2'b11:
    - idx = candidate; if last_valid and candidate == last_idx, idx = (candidate+1) mod NUM_MOLES.
    - mole_leds <= one-hot(idx); last_idx <= idx; last_valid <= 1.
    - timer <= TICKS_x - 1, where x is the difficulty sampled at this edge; mole_active <= 1; state <= UP.
    - The mole is visible for exactly TICKS_x cycles unless it is struck first.
  - enable with difficulty=11 is ignored.
- UP (evaluated in this priority order each edge):
  1. Any press bit set outside idx (a wrong press, including simultaneous correct and wrong presses): miss.
  2. press[idx]=1 and no other press bits: hit. This takes priority over a timeout in the same cycle.
  3. timer==0: miss (timeout).
  4. Otherwise timer <= timer-1.
- Hit:
  - score <= score+1, saturating at all-ones.
  - hit_pulse=1 for one cycle.
  - mole_leds <= 0, mole_active <= 0, state <= IDLE.
- Miss:
  - misses <= misses+1, saturating.
  - miss_pulse=1 for one cycle.
  - mole_leds <= 0, mole_active <= 0, state <= IDLE.
- enable arriving while in UP is dropped; it is not queued.
- Changing difficulty in UP does not affect the running timer.
- An enable on the same edge that the mole resolves is dropped, because the state is still UP at that edge.
- Latency:
  - enable to mole_leds: 1 edge.
  - Button rising edge (a synchronous input at edge t) to hit_pulse/miss_pulse: registered at edge t.
  - Pulses deassert on the following edge.
- Counters hold their values until reset; no wrap-around.

Test Plan:
- Bench setup: TICKS_EASY=10, TICKS_MED=6, TICKS_HARD=3, SCORE_W=4; the bench carries a reference LFSR model.
- Reset, then enable pulse at difficulty=00 -> mole_leds one-hot at the model index on the next edge. No press -> after exactly 10 cycles of UP: miss_pulse for 1 cycle, misses=1, mole_leds=0.
- Spawn, then press the correct button 2 cycles later -> hit_pulse for 1 cycle, score=1, state IDLE. A second press while in IDLE -> no change.
- Spawn, then press the correct and one wrong button in the same cycle -> miss_pulse, misses+1, score unchanged.
- difficulty=11 with enable pulses -> mole_leds stays 0. difficulty=10 -> mole stays up 3 cycles. Force the LFSR candidate to equal last_idx -> idx advances by 1 mod 4.
- Button held high across a spawn -> no hit; release then press -> hit. Correct press on the timer==0 cycle -> hit, not miss.
- 16 consecutive hits -> score saturates at 15. Assert reset mid-UP -> all outputs 0 on the next edge with no pulse. enable during UP -> ignored.
